// File: rtl/fetch_sequencer_if.sv
// Instruction-memory handshake bundle between the fetch sequencer and imem.
//   imem_req  : read request, held with imem_addr until imem_ack
//   imem_addr : 64-bit byte address of the instruction word
//   imem_ack  : memory accepted the request; imem_data valid this cycle
//   imem_data : 32-bit fetched instruction word
interface fetch_sequencer_if;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: fetches one instruction word, then steps through
// decoder-supplied micro-steps until the final step retires it and updates pc.
//   clock, reset  : system clock, asynchronous active-low reset
//   imem          : instruction-memory handshake (master side)
//   instruction   : instruction register presented to the decoders
//   state         : current micro-step presented to the decoders
//   instr_valid   : instruction/state are valid for execution
//   nextState     : next micro-step (0 = final step)
//   Psel, K, pc_in: pc update select, branch word offset, register pc source
//   stall         : freezes execution in EXEC
//   pc            : program counter
//   retire        : combinational pulse in the cycle an instruction completes
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  fetch_sequencer_if.master    imem,
  output logic [31:0]          instruction,
  output logic [1:0]           state,
  output logic                 instr_valid,
  input  logic [1:0]           nextState,
  input  logic [1:0]           Psel,
  input  logic [63:0]          K,
  input  logic [63:0]          pc_in,
  input  logic                 stall,
  output logic [63:0]          pc,
  output logic                 retire
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned SW   = 2;

  typedef enum logic {FETCH, EXEC} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [SW-1:0]   step_q, step_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      step_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      step_q  <= step_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, next-register and retire logic
  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    step_d  = step_q;
    req_d   = req_q;
    valid_d = valid_q;
    retire  = 1'b0;
    case (fsm_q)
      FETCH: begin
        // req_q is low only in the first cycle after reset release, so an
        // ack arriving before the request is raised is ignored.
        req_d   = 1'b1;
        valid_d = 1'b0;
        if (req_q && imem.imem_ack) begin
          instr_d = imem.imem_data;
          step_d  = '0;
          fsm_d   = EXEC;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (nextState != SW'(0)) begin
            step_d = nextState;
          end else begin
            retire  = 1'b1;
            step_d  = '0;
            fsm_d   = FETCH;
            req_d   = 1'b1;
            valid_d = 1'b0;
            case (Psel)
              2'b00:   pc_d = pc_q;
              2'b01:   pc_d = pc_q + XLEN'(4);
              2'b10:   pc_d = pc_in;
              default: pc_d = pc_q + {K[XLEN-3:0], 2'b00};
            endcase
          end
        end
      end
    endcase
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign state          = step_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a table of single-instruction
// vectors chained through the pc, plus hand sequences for delayed ack,
// multi-step execution, stall and asynchronous reset mid-instruction.
// Fetched words are queued and compared against the instruction register
// whenever the sequencer retires.
module tb_fetch_sequencer;
  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic        instr_valid;
  logic [1:0]  nextState;
  logic [1:0]  Psel;
  logic [63:0] K;
  logic [63:0] pc_in;
  logic        stall;
  logic [63:0] pc;
  logic        retire;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(.RESET_PC(64'd0)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus),
    .instruction (instruction),
    .state       (state),
    .instr_valid (instr_valid),
    .nextState   (nextState),
    .Psel        (Psel),
    .K           (K),
    .pc_in       (pc_in),
    .stall       (stall),
    .pc          (pc),
    .retire      (retire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0]  psel;
    logic [63:0] k;
    logic [63:0] pcin;
    logic [31:0] data;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard consumer: every retire must match the oldest fetched word
  always @(negedge clock) begin
    if (reset && retire) begin
      retire_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_retire: got instruction %h expected no retire", instruction);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (instruction !== e) begin
          errors++;
          $display("FAIL sb_retire_instr: got %h expected %h", instruction, e);
        end
      end
    end
  end

  // One-cycle fetch with immediate ack from a FETCH cycle with imem_req high
  task automatic fetch_instr(input logic [31:0] data, input logic [63:0] exp_addr);
    imem_bus.imem_ack  = 1'b1;
    imem_bus.imem_data = data;
    #1;
    check("fetch_req", 64'(imem_bus.imem_req), 64'd1);
    check("fetch_addr", imem_bus.imem_addr, exp_addr);
    check("fetch_valid_low", 64'(instr_valid), 64'd0);
    sb.push_back(data);
    tick();
    imem_bus.imem_ack = 1'b0;
    check("exec_valid", 64'(instr_valid), 64'd1);
    check("exec_state0", 64'(state), 64'd0);
    check("exec_instr", 64'(instruction), 64'(data));
  endtask

  // Final micro-step: retires and applies the pc update
  task automatic exec_final(input logic [1:0] psel, input logic [63:0] k, input logic [63:0] pcin);
    nextState = 2'b00;
    Psel      = psel;
    K         = k;
    pc_in     = pcin;
    stall     = 1'b0;
    #1;
    check("final_retire", 64'(retire), 64'd1);
    tick();
    check("back_to_fetch_req", 64'(imem_bus.imem_req), 64'd1);
    check("back_to_fetch_valid", 64'(instr_valid), 64'd0);
    check("final_state0", 64'(state), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev_pc;
    int          r0;

    vecs[0] = '{2'b01, 64'd0, 64'd0, 32'h1111_0001, 64'h4};
    vecs[1] = '{2'b01, 64'd0, 64'd0, 32'h2222_0002, 64'h8};
    vecs[2] = '{2'b11, 64'd2, 64'd0, 32'h3333_0003, 64'h10};
    vecs[3] = '{2'b10, 64'd0, 64'h100, 32'h4444_0004, 64'h100};
    vecs[4] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 32'h5555_0005, 64'hF8};
    vecs[5] = '{2'b00, 64'd7, 64'h999, 32'h6666_0006, 64'hF8};
    vecs[6] = '{2'b10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_0007, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[7] = '{2'b01, 64'd0, 64'd0, 32'h8888_0008, 64'h0};
    vecs[8] = '{2'b11, 64'h4000_0000_0000_0000, 64'd0, 32'h9999_0009, 64'h0};
    vecs[9] = '{2'b11, 64'd1, 64'd0, 32'hAAAA_000A, 64'h4};

    reset = 1'b0;
    imem_bus.imem_ack  = 1'b0;
    imem_bus.imem_data = '0;
    nextState = '0;
    Psel      = '0;
    K         = '0;
    pc_in     = '0;
    stall     = 1'b0;

    // Reset values
    #12;
    check("rst_req", 64'(imem_bus.imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);

    // Release; an ack before imem_req rises is ignored
    reset = 1'b1;
    imem_bus.imem_ack  = 1'b1;
    imem_bus.imem_data = 32'hDEAD_BEEF;
    #1;
    check("rel_req_low", 64'(imem_bus.imem_req), 64'd0);
    tick();
    check("rel_req_high", 64'(imem_bus.imem_req), 64'd1);
    check("rel_still_fetch", 64'(instr_valid), 64'd0);
    check("rel_instr_zero", 64'(instruction), 64'd0);
    imem_bus.imem_ack = 1'b0;

    // Table: one instruction per vector, pc chained through the table
    prev_pc = 64'd0;
    for (int i = 0; i < 10; i++) begin
      fetch_instr(vecs[i].data, prev_pc);
      exec_final(vecs[i].psel, vecs[i].k, vecs[i].pcin);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      prev_pc = vecs[i].exp_pc;
    end

    // Multi-step 0->1->2->retire; stall ignored in FETCH, ack ignored in EXEC,
    // Psel ignored on non-final steps
    stall = 1'b1;
    fetch_instr(32'hA5A5_0001, 64'h4);
    stall = 1'b0;
    nextState = 2'b01;
    Psel = 2'b11;
    K = 64'd5;
    imem_bus.imem_ack  = 1'b1;
    imem_bus.imem_data = 32'hBAD0_BAD0;
    #1;
    check("ms0_no_retire", 64'(retire), 64'd0);
    check("ms0_no_req", 64'(imem_bus.imem_req), 64'd0);
    tick();
    check("ms1_state", 64'(state), 64'd1);
    check("ms1_pc", pc, 64'h4);
    check("ms1_instr", 64'(instruction), 64'hA5A5_0001);
    nextState = 2'b10;
    #1;
    check("ms1_no_retire", 64'(retire), 64'd0);
    tick();
    check("ms2_state", 64'(state), 64'd2);
    check("ms2_pc", pc, 64'h4);
    check("ms2_valid", 64'(instr_valid), 64'd1);
    imem_bus.imem_ack = 1'b0;
    r0 = retire_cnt;
    exec_final(2'b01, 64'd0, 64'd0);
    check("ms_pc", pc, 64'h8);
    check("ms_single_retire", 64'(retire_cnt), 64'(r0 + 1));

    // Ack delayed three cycles with changing data
    for (int c = 0; c < 3; c++) begin
      imem_bus.imem_data = 32'h1000_0000 + 32'(c);
      #1;
      check("wait_addr", imem_bus.imem_addr, 64'h8);
      check("wait_req", 64'(imem_bus.imem_req), 64'd1);
      tick();
      check("wait_instr_held", 64'(instruction), 64'hA5A5_0001);
      check("wait_valid_low", 64'(instr_valid), 64'd0);
    end
    fetch_instr(32'hC0DE_0003, 64'h8);
    exec_final(2'b01, 64'd0, 64'd0);
    check("delay_pc", pc, 64'hC);

    // Stall four cycles at state 1, then release with Psel=10
    fetch_instr(32'h5151_0005, 64'hC);
    nextState = 2'b01;
    Psel = 2'b00;
    tick();
    check("st_state1", 64'(state), 64'd1);
    stall = 1'b1;
    nextState = 2'b00;
    Psel = 2'b01;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("st_no_retire", 64'(retire), 64'd0);
      tick();
      check("st_state", 64'(state), 64'd1);
      check("st_pc", pc, 64'hC);
      check("st_instr", 64'(instruction), 64'h5151_0005);
      check("st_valid", 64'(instr_valid), 64'd1);
    end
    exec_final(2'b10, 64'd0, 64'h2000);
    check("st_pc_in", pc, 64'h2000);

    // Asynchronous reset in EXEC at state 1
    fetch_instr(32'h7777_0007, 64'h2000);
    nextState = 2'b01;
    tick();
    check("rx_state1", 64'(state), 64'd1);
    #2;
    reset = 1'b0;
    imem_bus.imem_ack  = 1'b1;
    imem_bus.imem_data = 32'hFEED_FACE;
    #1;
    check("rx_pc", pc, 64'd0);
    check("rx_state", 64'(state), 64'd0);
    check("rx_instr", 64'(instruction), 64'd0);
    check("rx_valid", 64'(instr_valid), 64'd0);
    check("rx_req", 64'(imem_bus.imem_req), 64'd0);
    check("rx_retire", 64'(retire), 64'd0);
    sb.delete();
    tick();
    tick();
    check("rx_hold_instr", 64'(instruction), 64'd0);
    check("rx_hold_req", 64'(imem_bus.imem_req), 64'd0);
    reset = 1'b1;
    imem_bus.imem_ack = 1'b0;
    nextState = 2'b00;
    #1;
    check("rx_rel_req_low", 64'(imem_bus.imem_req), 64'd0);
    tick();
    check("rx_restart_req", 64'(imem_bus.imem_req), 64'd1);
    check("rx_restart_addr", imem_bus.imem_addr, 64'd0);
    fetch_instr(32'h8888_0008, 64'd0);
    exec_final(2'b01, 64'd0, 64'd0);
    check("rx_final_pc", pc, 64'h4);

    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
